// File: rtl/arb_rr_3_if.sv
// Handshake bundle between the three-way round-robin arbiter and its requesters/downstream port.
// The master side is the arbiter itself; the slave side is whatever drives requests and ready.
interface arb_rr_3_if;
  logic [2:0] req;
  logic       down_ready;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       down_valid;
  logic       busy;

  modport master (
    input  req,
    input  down_ready,
    output gnt,
    output sel,
    output down_valid,
    output busy
  );

  modport slave (
    output req,
    output down_ready,
    input  gnt,
    input  sel,
    input  down_valid,
    input  busy
  );
endinterface

// File: rtl/arb_rr_3.sv
// Round-robin arbiter sharing one downstream port among requesters a/b/c, with each tenure
// bounded to MAX_BEATS completed beats so that no requester can starve the others.
module arb_rr_3 #(
  parameter int MAX_BEATS = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  arb_rr_3_if.master bus
);

  localparam int                 CNT_W    = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t             r_state;
  logic [1:0]         r_owner;
  logic [1:0]         r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_gnt;
  logic [1:0]         r_sel;

  logic               w_busy;
  logic               w_ownerReq;
  logic               w_downValid;
  logic               w_beat;
  logic               w_lastBeat;
  logic               w_release;
  logic [1:0]         w_relPtr;
  logic [1:0]         w_arbPtr;
  logic [1:0]         w_cand0;
  logic [1:0]         w_cand1;
  logic [1:0]         w_cand2;
  logic               w_winValid;
  logic [1:0]         w_winIdx;

  function automatic logic [1:0] nextIdx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] oneHot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  assign w_busy      = (r_state == S_GRANT);
  assign w_ownerReq  = bus.req[r_owner];
  assign w_downValid = w_busy & w_ownerReq;
  assign w_beat      = w_downValid & bus.down_ready;
  assign w_lastBeat  = w_beat & (r_cnt == LAST_CNT);
  assign w_release   = w_busy & (~w_ownerReq | w_lastBeat);

  // On release the pointer moves past the old owner, which leaves that owner last in the scan.
  assign w_relPtr = nextIdx(r_owner);
  assign w_arbPtr = w_release ? w_relPtr : r_ptr;

  assign w_cand0 = w_arbPtr;
  assign w_cand1 = nextIdx(w_cand0);
  assign w_cand2 = nextIdx(w_cand1);

  assign w_winValid = bus.req[w_cand0] | bus.req[w_cand1] | bus.req[w_cand2];
  assign w_winIdx   = bus.req[w_cand0] ? w_cand0 :
                      bus.req[w_cand1] ? w_cand1 : w_cand2;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_gnt   <= 3'b000;
      r_sel   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_winValid) begin
            r_state <= S_GRANT;
            r_owner <= w_winIdx;
            r_gnt   <= oneHot(w_winIdx);
            r_sel   <= w_winIdx;
            r_cnt   <= '0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_ptr <= w_relPtr;
            r_cnt <= '0;
            // Hand over without an idle bubble when anyone is still asking; sel holds otherwise.
            if (w_winValid) begin
              r_owner <= w_winIdx;
              r_gnt   <= oneHot(w_winIdx);
              r_sel   <= w_winIdx;
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= 3'b000;
            end
          end else if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= 3'b000;
        end
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.sel        = r_sel;
  assign bus.busy       = w_busy;
  assign bus.down_valid = w_downValid;

endmodule
